// File: rtl/mem_arb_pkg.sv
// Shared constants and FSM state type for the memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: byte enables and replicated store data by access size.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SIZE_HALF: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with fetch anti-starvation.
// Optional memory timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic [31:0] i_rdata_o,
  output logic        i_ack_o,
  input  logic        d_rd_i,
  input  logic        d_wr_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic [1:0]  d_size_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        m_req_o,
  output logic        m_we_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_be_o,
  input  logic [31:0] m_rdata_i,
  input  logic        m_ack_i,
  output logic        err_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          m_req_q, m_we_q, i_ack_q, d_ack_q;
  logic [31:0]   m_addr_q, m_wdata_q, i_rdata_q, d_rdata_q;
  logic [3:0]    m_be_q;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic          d_req, fetch_starved, tmo_hit;

  mem_lane_align u_align (
    .size_i   (d_size_i),
    .addr_lo_i(d_addr_i[1:0]),
    .wdata_i  (d_wdata_i),
    .be_o     (al_be),
    .wdata_o  (al_wdata)
  );

  assign d_req         = d_rd_i | d_wr_i;
  assign fetch_starved = i_req_i && (starve_q == SW'(STARVE_LIMIT));
  assign starve_d      = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign tmo_hit = !m_ack_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || !m_req_q || m_ack_i || tmo_hit) tmo_q <= '0;
    else                                           tmo_q <= tmo_q + 1'b1;
  end
`else
  wire unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (d_req && !fetch_starved) begin
            state_q   <= DACCESS;
            m_req_q   <= 1'b1;
            m_we_q    <= d_wr_i;
            m_addr_q  <= d_addr_i;
            m_wdata_q <= al_wdata;
            m_be_q    <= al_be;
            if (i_req_i) starve_q <= starve_d;
          end else if (i_req_i) begin
            state_q   <= IFETCH;
            m_req_q   <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= i_addr_i;
            m_wdata_q <= '0;
            m_be_q    <= 4'b1111;
            starve_q  <= '0;
          end
        end
        IFETCH, DACCESS: begin
          // A timeout completes the access like an ack but returns zero data.
          if (m_ack_i || tmo_hit) begin
            state_q <= IDLE;
            m_req_q <= 1'b0;
            if (state_q == IFETCH) begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= m_ack_i ? m_rdata_i : '0;
            end else begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= (m_ack_i && !m_we_q) ? m_rdata_i : '0;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            err_q <= !m_ack_i;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_req_o   = m_req_q;
  assign m_we_o    = m_we_q;
  assign m_addr_o  = m_addr_q;
  assign m_wdata_o = m_wdata_q;
  assign m_be_o    = m_be_q;
  assign i_ack_o   = i_ack_q;
  assign i_rdata_o = i_rdata_q;
  assign d_ack_o   = d_ack_q;
  assign d_rdata_o = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int LIM = 4;
  localparam int TMO = 8;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic [31:0] i_rdata_o;
  logic        i_ack_o;
  logic        d_rd_i, d_wr_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [1:0]  d_size_i;
  logic [31:0] d_rdata_o;
  logic        d_ack_o;
  logic        m_req_o, m_we_o;
  logic [31:0] m_addr_o, m_wdata_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_rdata_i;
  logic        m_ack_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o), .i_ack_o(i_ack_o),
    .d_rd_i(d_rd_i), .d_wr_i(d_wr_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_size_i(d_size_i), .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_be_o(m_be_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i), .err_o(err_o)
  );

  int n_chk = 0;
  int n_bad = 0;
  int starve_m = 0;
  bit f_pend = 0, d_pend = 0;
  logic [3:0]  last_be;
  logic [31:0] last_wdata;
  logic        last_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'd0:    return 4'(1 << (a % 4));
      2'd1:    return 4'(3 << (a & 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'd0:    return w[7:0] * 32'h0101_0101;
      2'd1:    return w[15:0] * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // Entered #1 after an edge with the DUT idle; requests already on the pins.
  task automatic do_txn(input int lat, input logic [31:0] rd, output bit got_data);
    bit          dwin;
    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;
    dwin = d_pend && !(f_pend && starve_m == LIM);
    if (dwin) begin
      if (f_pend) starve_m = (starve_m < LIM) ? starve_m + 1 : LIM;
      ea  = d_addr_i;
      ewe = d_wr_i;
      eb  = exp_be(d_size_i, d_addr_i);
      ew  = exp_wd(d_size_i, d_wdata_i);
    end else begin
      starve_m = 0;
      ea  = i_addr_i;
      ewe = 1'b0;
      eb  = 4'hF;
      ew  = '0;
    end
    @(posedge clk_i); #1;
    chk("grant_req", m_req_o, 1);
    chk("ack_pulse", {i_ack_o, d_ack_o}, 0);
    chk("addr", m_addr_o, ea);
    chk("be", m_be_o, eb);
    chk("we", m_we_o, ewe);
    if (ewe) chk("wdata", m_wdata_o, ew);
    last_be = m_be_o; last_wdata = m_wdata_o; last_we = m_we_o;
    for (int k = 0; k < lat; k++) begin
      @(posedge clk_i); #1;
      chk("wait_stable", {m_req_o, m_we_o, m_be_o, m_addr_o[25:0]},
          {1'b1, ewe, eb, ea[25:0]});
      chk("wait_noack", {i_ack_o, d_ack_o, err_o}, 0);
      chk("wait_rdz", i_rdata_o | d_rdata_o, 0);
    end
    @(negedge clk_i);
    m_ack_i = 1'b1; m_rdata_i = rd;
    @(posedge clk_i); #1;
    m_ack_i = 1'b0; m_rdata_i = $urandom;
    got_data = d_ack_o;
    chk("owner_ack", {i_ack_o, d_ack_o}, dwin ? 2'b01 : 2'b10);
    chk("rdata", dwin ? d_rdata_o : i_rdata_o, (dwin && ewe) ? 32'h0 : rd);
    chk("other_rdz", dwin ? i_rdata_o : d_rdata_o, 0);
    chk("done_state", {m_req_o, err_o}, 0);
    if (dwin) begin d_rd_i = 0; d_wr_i = 0; d_pend = 0; end
    else      begin i_req_i = 0; f_pend = 0; end
  endtask

  task automatic new_data(input int op);
    d_rd_i = op[0]; d_wr_i = op[1];
    d_addr_i = $urandom; d_wdata_i = $urandom; d_size_i = 2'($urandom_range(0, 3));
    d_pend = 1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(posedge clk_i); @(posedge clk_i); #1;
    reset_i = 1'b0;
    starve_m = 0;
  endtask

  bit g;
  int cnt;

  initial begin
    reset_i = 1; i_req_i = 0; i_addr_i = 0; d_rd_i = 0; d_wr_i = 0;
    d_addr_i = 0; d_wdata_i = 0; d_size_i = 0; m_rdata_i = 0; m_ack_i = 0;
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rst_ctl", {m_req_o, m_we_o, i_ack_o, d_ack_o, err_o, m_be_o}, 0);
    chk("rst_data", m_addr_o | m_wdata_o | i_rdata_o | d_rdata_o, 0);
    reset_i = 0;

    // Lone byte load
    d_rd_i = 1; d_wr_i = 0; d_addr_i = 32'h103; d_size_i = 0; d_wdata_i = 0; d_pend = 1;
    do_txn(0, 32'hAABBCCDD, g);
    chk("load_be", last_be, 4'b1000);
    chk("load_we", last_we, 0);

    // Half store, also word-aligned half check of replication
    d_rd_i = 0; d_wr_i = 1; d_addr_i = 32'h202; d_wdata_i = 32'h1234ABCD; d_size_i = 1; d_pend = 1;
    do_txn(0, 32'h5555_5555, g);
    chk("half_be", last_be, 4'b1100);
    chk("half_wd", last_wdata, 32'hABCDABCD);

    // Wait states
    new_data(3);
    do_txn(5, 32'h0BAD_F00D, g);
    @(posedge clk_i); #1;
    chk("single_pulse", {i_ack_o, d_ack_o}, 0);

    // Starvation pattern from a clean counter
    do_reset();
    for (int k = 0; k < 10; k++) begin
      if (!d_pend) begin d_rd_i = 1; d_wr_i = 0; d_addr_i = 32'h1000 + k; d_size_i = 2; d_pend = 1; end
      if (!f_pend) begin i_req_i = 1; i_addr_i = 32'h8000 + k; f_pend = 1; end
      do_txn(0, $urandom, g);
      chk("starve_seq", g, (k % 5) != 4);
    end
    i_req_i = 0; f_pend = 0; d_rd_i = 0; d_pend = 0;
    @(posedge clk_i); #1;

    // Reset during a data access
    do_reset();
    new_data(1);
    @(posedge clk_i); #1;
    chk("pre_rst_req", m_req_o, 1);
    reset_i = 1;
    @(posedge clk_i); #1;
    chk("rst_mid_req", m_req_o, 0);
    chk("rst_mid_ack", {i_ack_o, d_ack_o, err_o}, 0);
    reset_i = 0; starve_m = 0;
    do_txn(1, $urandom, g);

`ifdef MEM_ARB_TIMEOUT_EN
    i_req_i = 1; i_addr_i = 32'hDEAD_0000; f_pend = 1; starve_m = 0;
    @(posedge clk_i); #1;
    cnt = 0;
    while (!i_ack_o && cnt < 20) begin @(posedge clk_i); #1; cnt++; end
    chk("tmo_cycles", cnt, TMO);
    chk("tmo_err", {err_o, i_ack_o}, 2'b11);
    chk("tmo_rdata", i_rdata_o, 0);
    i_req_i = 0; f_pend = 0;
    @(posedge clk_i); #1;
    chk("tmo_err_pulse", err_o, 0);
`endif

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      if (!d_pend && ($urandom % 3 != 0)) new_data($urandom_range(1, 3));
      if (!f_pend && ($urandom % 3 != 0)) begin i_req_i = 1; i_addr_i = $urandom; f_pend = 1; end
      if (!d_pend && !f_pend) begin
        @(posedge clk_i); #1;
        chk("idle_noreq", m_req_o, 0);
      end else begin
        do_txn($urandom_range(0, 3), $urandom, g);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
